// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM state, opcode and ALU-operation constants for ctrl_seq_unit
package ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_TRAP} state_t;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_LAST = 4'd8;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_of = ALU_ADD;
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      OP_XOR:  alu_of = ALU_XOR;
      OP_NOT:  alu_of = ALU_NOT;
      OP_SHL:  alu_of = ALU_SHL;
      OP_SHR:  alu_of = ALU_SHR;
      default: alu_of = 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder (opcode in; alu_op, is_nop, is_illegal out)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                is_nop,
  output logic                is_illegal
);
  // any bit above bit 3 also makes the value exceed OP_LAST
  assign is_illegal = opcode > OPCODE_W'(OP_LAST);
  assign is_nop = opcode == '0;
  assign alu_op = (is_illegal || is_nop) ? '0 : ALUOP_W'(alu_of(opcode[3:0]));
endmodule

// File: rtl/ctrl_seq_unit.sv
// ctrl_seq_unit: IDLE/DECODE/EXEC/WB/TRAP instruction sequencer driving ALU and register-file controls
// Ports: clk, rst (async high); instr_valid/instr_ready/opcode from fetch; exec_stall, trap_clr;
// alu_op, alu_en, reg_write, done, illegal; retired_cnt/illegal_cnt (present with CTRL_SEQ_PERF_CNT_EN, else 0)
module ctrl_seq_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                exec_stall,
  input  logic                trap_clr,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_en,
  output logic                reg_write,
  output logic                done,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    illegal_cnt
);
  state_t state_q;
  logic [OPCODE_W-1:0] ir_q;
  logic [ALUOP_W-1:0] alu_op_q, dec_alu_op;
  logic alu_en_q, reg_write_q, done_q, illegal_q, dec_nop, dec_ill;
  ctrl_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_dec (
    .opcode(ir_q),
    .alu_op(dec_alu_op),
    .is_nop(dec_nop),
    .is_illegal(dec_ill)
  );
  assign instr_ready = state_q == S_IDLE;
  assign alu_op = alu_op_q;
  assign alu_en = alu_en_q;
  assign reg_write = reg_write_q;
  assign done = done_q;
  assign illegal = illegal_q;
  // outputs are loaded with the value belonging to the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      alu_op_q <= '0;
      alu_en_q <= 1'b0;
      reg_write_q <= 1'b0;
      done_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      alu_en_q <= 1'b0;
      reg_write_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (instr_valid) begin
          ir_q <= opcode;
          state_q <= S_DECODE;
          done_q <= opcode == '0;
        end
        S_DECODE: begin
          alu_op_q <= dec_alu_op;
          if (dec_ill) begin
            state_q <= S_TRAP;
            illegal_q <= 1'b1;
          end else if (dec_nop) state_q <= S_IDLE;
          else begin
            state_q <= S_EXEC;
            alu_en_q <= 1'b1;
          end
        end
        S_EXEC: if (exec_stall) alu_en_q <= 1'b1;
        else begin
          state_q <= S_WB;
          reg_write_q <= 1'b1;
          done_q <= 1'b1;
        end
        S_WB: state_q <= S_IDLE;
        S_TRAP: if (trap_clr) begin
          state_q <= S_IDLE;
          illegal_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, ill_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(done_q);
      ill_cnt_q <= ill_cnt_q + CNT_W'(state_q == S_DECODE && dec_ill);
    end
  end
  assign retired_cnt = retired_q;
  assign illegal_cnt = ill_cnt_q;
`else
  assign retired_cnt = '0;
  assign illegal_cnt = '0;
`endif
endmodule
